ifu_itcm_rd_rsp: RTL

AXI4 read-channel responder in front of the instruction TCM, serving the 64-bit fetch requests issued by the IFU PC/fetch stage. It accepts AR requests (single beat or INCR/FIXED bursts), sequences a 1-cycle-latency synchronous SRAM, and returns 64-bit R beats through a 2-entry output buffer. Back-pressure on `rready` never drops data. Throughput is one beat per cycle.

---
 rtl/alioth_axi_pkg.sv | 25 ++
 rtl/ifu_itcm_rbuf.sv | 53 +++++
 rtl/ifu_itcm_rd_rsp.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alioth_axi_pkg.sv
// Shared AXI read-channel types for the IFU/ITCM fetch path.
package alioth_axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_DATA_W = 64;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    axi_resp_e             resp;
    logic                  last;
  } rd_beat_t;

endpackage

// File: rtl/ifu_itcm_rbuf.sv
// Two-entry R-beat FIFO; entry 0 is always the head so outputs come straight from a register.
module ifu_itcm_rbuf
  import alioth_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rd_beat_t   push_beat,
  input  logic       pop,
  output rd_beat_t   head,
  output logic       head_valid,
  output logic [1:0] count
);

  rd_beat_t   e0_q;
  rd_beat_t   e1_q;
  logic [1:0] cnt_q;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_beat;
          else               e1_q <= push_beat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= (cnt_q == 2'd2) ? e1_q : '0;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= push_beat;
          end else begin
            e0_q <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = e0_q;
  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

endmodule

// File: rtl/ifu_itcm_rd_rsp.sv
// AXI4 read responder for the instruction TCM: AR capture, SRAM sequencing, buffered R beats.
module ifu_itcm_rd_rsp
  import alioth_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          arid_i,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic [7:0]                   arlen_i,
  input  logic [1:0]                   arburst_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [ID_WIDTH-1:0]          rid_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rlast_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic                         mem_en_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

  localparam int unsigned WA_W   = ADDR_WIDTH - 3;
  localparam int unsigned MA_W   = $clog2(MEM_DEPTH);
  localparam int unsigned BEAT_W = 9;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q;
  logic [WA_W-1:0]     waddr_q;
  logic [BEAT_W-1:0]   beats_q;
  logic                fixed_q;
  logic                infl_q, infl_oor_q, infl_last_q;
  logic [ID_WIDTH-1:0] infl_id_q;

  logic       ar_hs, issue, pop, oor, last_issue;
  logic [2:0] occ;
  logic [1:0] rb_count;
  rd_beat_t   push_beat, head;
  logic       head_valid;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^araddr_i[2:0];

  assign pop        = head_valid & rready_i;
  assign occ        = 3'(rb_count) + 3'(infl_q) - 3'(pop);
  assign oor        = (waddr_q >= WA_W'(MEM_DEPTH));
  assign last_issue = (beats_q == BEAT_W'(1));
  assign ar_hs      = arready_o & arvalid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Issue whenever the buffer can still absorb the beat after this cycle's pop.
  always_comb begin
    state_d   = state_q;
    arready_o = 1'b0;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) state_d = ST_BURST;
      end
      ST_BURST: begin
        issue = (occ < 3'd2);
        if (issue && last_issue) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      waddr_q <= '0;
      beats_q <= '0;
      fixed_q <= 1'b0;
    end else if (ar_hs) begin
      id_q    <= arid_i;
      waddr_q <= araddr_i[ADDR_WIDTH-1:3];
      beats_q <= BEAT_W'(arlen_i) + BEAT_W'(1);
      fixed_q <= (arburst_i == AXI_BURST_FIXED);
    end else if (issue) begin
      if (!fixed_q) waddr_q <= waddr_q + WA_W'(1);
      beats_q <= beats_q - BEAT_W'(1);
    end
  end

  // Out-of-range beats still take the inflight slot so response order is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_oor_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_id_q   <= '0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        infl_oor_q  <= oor;
        infl_last_q <= last_issue;
        infl_id_q   <= id_q;
      end
    end
  end

  always_comb begin
    push_beat      = '0;
    push_beat.id   = AXI_ID_W'(infl_id_q);
    push_beat.data = infl_oor_q ? '0 : AXI_DATA_W'(mem_rdata_i);
    push_beat.resp = infl_oor_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    push_beat.last = infl_last_q;
  end

  ifu_itcm_rbuf u_rbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (infl_q),
    .push_beat  (push_beat),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (rb_count)
  );

  assign mem_en_o   = issue & ~oor;
  assign mem_addr_o = waddr_q[MA_W-1:0];
  assign rvalid_o   = head_valid;
  assign rid_o      = ID_WIDTH'(head.id);
  assign rdata_o    = DATA_WIDTH'(head.data);
  assign rresp_o    = head.resp;
  assign rlast_o    = head.last;

endmodule
